fft_addr_gen_cfg: RTL and testbench
===================================

Name: fft_addr_gen_cfg

Overview:
Runtime-configurable address and twiddle-index generator for the shared-butterfly, in-place radix-2 FFT engine.
- Supports both DIT and DIF ordering, selected per transform.
- Supports any transform size 2^log2n up to 2^MAX_LOG2N, selected per transform.
- Sequences the whole transform through an internal FSM: load, per-stage compute with pipeline drain, and unload.
- Drives the single data RAM's read/write ports and the twiddle ROM index. Sits between the top-level controller and the butterfly datapath.

Parameters:
MAX_LOG2N, 13, log2 of largest supported FFT size; address width AW = MAX_LOG2N
PIPE_LAT, 3, cycles from RAM read address to butterfly result write (read latency + butterfly pipeline); must be >= 1
SW, $clog2(MAX_LOG2N+1), width of the stage and log2n fields

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a transform; honoured only in IDLE
mode_dif  in  1  sampled at start: 0 = DIT, 1 = DIF
log2n  in  SW  sampled at start; legal range 1..MAX_LOG2N; values outside this range are clamped to MAX_LOG2N
in_valid  in  1  input sample present (LOAD)
in_ready  out  1  high throughout LOAD
rd_en  out  1  RAM read strobe
rd_addr  out  AW  RAM read address
wr_en  out  1  RAM write strobe
wr_addr  out  AW  RAM write address
wr_sel_in  out  1  1 = write data comes from the input stream; 0 = write data comes from the butterfly
k  out  AW-1  twiddle index (W_N^k scaled to MAX_LOG2N table)
stage  out  SW  current compute stage
out_last  out  1  accompanies the final unload read
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset:
  - FSM goes to IDLE; all counters are cleared.
  - All outputs are 0; in_ready=0.
  - The PIPE_LAT delay line is flushed: no stale wr_en may fire after reset.
  - Reset mid-transform aborts immediately, and done is not pulsed.
- Notation: N = 2^L, where L is the latched log2n. cnt is the counter in use; only its low L bits are meaningful and higher address bits are driven 0.
- FSM: IDLE -> LOAD -> COMPUTE -> DRAIN -> (COMPUTE next stage | UNLOAD) -> IDLE.
- IDLE:
  - start latches mode_dif and L, then moves to LOAD.
  - A start asserted in any other state is ignored.
- LOAD:
  - in_ready=1.
  - On each in_valid, a write is issued combinationally in the same cycle: wr_en=1, wr_sel_in=1, and cnt increments.
  - wr_addr = bitrev_L(cnt) for DIT, or cnt for DIF.
  - When the N-th sample is accepted, go to COMPUTE with stage=0 and cnt=0.
  - Gaps in in_valid are allowed.
- COMPUTE (stage s): one read per cycle for N cycles, giving N/2 butterflies of 2 reads each.
  - Butterfly index b = cnt>>1; the read of x0 occurs when cnt[0]=0 and the read of x1 when cnt[0]=1.
  - DIT: span = 2^s; x0 = ((b>>s)<<(s+1)) | (b & (span-1)); x1 = x0 + span; k = (b & (span-1)) << (MAX_LOG2N-1-s).
  - DIF: span = 2^(L-1-s); x0 = ((b>>(L-1-s))<<(L-s)) | (b & (span-1)); x1 = x0 + span; k = (b & (span-1)) << (MAX_LOG2N-L+s).
  - k is held for both read cycles of a butterfly.
  - rd_en=1, and rd_addr = x0 or x1 combinationally from cnt.
- Write-back:
  - wr_en, wr_addr, and wr_sel_in=0 are rd_en and rd_addr delayed by exactly PIPE_LAT registers.
  - This applies in every state; the delay line is clocked continuously.
- DRAIN:
  - Lasts PIPE_LAT cycles with rd_en=0, so the last write of stage s lands before stage s+1 reads (no RAW hazard).
  - Then, if s = L-1, go to UNLOAD; otherwise s+1 and back to COMPUTE.
  - stage increments on the COMPUTE entry.
- UNLOAD:
  - N cycles with rd_en=1.
  - rd_addr = cnt for DIT, or bitrev_L(cnt) for DIF.
  - out_last=1 when cnt=N-1.
  - The next cycle goes to IDLE with done=1.
- Cycle count, start to done: N (load, if gap-free) + L*(N+PIPE_LAT) + N + 1.
- Arithmetic: all address arithmetic is modulo 2^AW. x1 never exceeds N-1 for legal L.

Test Plan:
- DIT, L=3, PIPE_LAT=3:
  - Load samples 0..7 -> wr_addr 0,4,2,6,1,5,3,7.
  - Stage 0 rd_addr 0,1,2,3,4,5,6,7 with k=0.
  - Stage 1 rd_addr 0,2,1,3,4,6,5,7 with k(MAX_LOG2N=3)=0,2,0,2.
  - Stage 2 rd_addr 0,4,1,5,2,6,3,7 with k=0,1,2,3.
  - done at cycle 8+3*11+8+1=50 after start.
- DIF, L=3:
  - Stage 0 pairs (0,4),(1,5),(2,6),(3,7) with k=0,1,2,3.
  - Stage 1 pairs (0,2),(1,3),(4,6),(5,7) with k=0,2,0,2.
  - Unload rd_addr 0,4,2,6,1,5,3,7, with out_last on the 8th read.
- Write-back alignment: every wr_addr in COMPUTE equals the rd_addr from 3 cycles earlier.
  - The last stage-s write precedes the first stage-s+1 read.
  - No wr_en occurs during UNLOAD beyond the drain of the previous stage.
- Runtime size change: L=13, MAX_LOG2N=13, followed by back-to-back L=4.
  - The L=4 run uses only addresses 0..15, with bits [12:4]=0.
  - The L=4 run's k stride is scaled correctly: at stage 0, DIT k=0.
- Handshake/control:
  - in_valid toggling every other cycle during LOAD extends LOAD to 2N cycles, with no missed or duplicate addresses.
  - start pulses during COMPUTE are ignored.
- Reset mid-COMPUTE (stage 1, cnt=5):
  - The next cycle shows IDLE, busy=0, and wr_en=0 for all following cycles.
  - No done pulse occurs.
  - A fresh start runs normally.

Source files
------------

// File: rtl/fft_addr_gen_cfg_if.sv
// Bundle between the FFT controller/RAM side and the address generator.
// The master modport is the controller and testbench side; the slave modport is the generator.
interface fft_addr_gen_cfg_if #(
    parameter int MAX_LOG2N = 13,
    parameter int SW        = $clog2(MAX_LOG2N + 1)
);
    localparam int AW = MAX_LOG2N;

    logic          start;
    logic          mode_dif;
    logic [SW-1:0] log2n;
    logic          in_valid;
    logic          in_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_sel_in;
    logic [AW-2:0] k;
    logic [SW-1:0] stage;
    logic          out_last;
    logic          busy;
    logic          done;

    modport master (
        output start, mode_dif, log2n, in_valid,
        input  in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_sel_in, k, stage, out_last, busy, done
    );

    modport slave (
        input  start, mode_dif, log2n, in_valid,
        output in_ready, rd_en, rd_addr, wr_en, wr_addr, wr_sel_in, k, stage, out_last, busy, done
    );
endinterface

// File: rtl/fft_addr_gen_cfg.sv
// Address and twiddle-index sequencer for an in-place radix-2 FFT, runtime DIT/DIF and size.
// state   | meaning
// IDLE    | waiting for start
// LOAD    | streaming N input samples into RAM
// COMPUTE | one butterfly operand read per cycle for the current stage
// DRAIN   | PIPE_LAT idle cycles so the stage's last write lands before the next stage reads
// UNLOAD  | N output reads in natural order
module fft_addr_gen_cfg #(
    parameter int MAX_LOG2N = 13,
    parameter int PIPE_LAT  = 3,
    parameter int SW        = $clog2(MAX_LOG2N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    fft_addr_gen_cfg_if.slave bus
);
    localparam int AW = MAX_LOG2N;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD} state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [SW-1:0] l_q, l_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          done_q, done_d;
    logic [PIPE_LAT-1:0] dly_en_q, dly_en_d;
    logic [AW-1:0] dly_addr_q [PIPE_LAT];
    logic [AW-1:0] dly_addr_d [PIPE_LAT];

    logic [AW-1:0] n_m1, rev_cnt, b, span_m1, x0, x1, rd_addr_c;
    logic [SW-1:0] sh, ksh, l_in;
    logic [AW-2:0] k_c;
    logic          last_cnt, load_wr;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x, input logic [SW-1:0] l);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
        return r >> (SW'(AW) - l);
    endfunction

    // DIT and DIF share one formula once the span exponent is chosen; k shift is MAX_LOG2N-1-sh.
    always_comb begin
        n_m1     = AW'(((AW+1)'(1) << l_q) - (AW+1)'(1));
        last_cnt = (cnt_q == n_m1);
        rev_cnt  = bitrev(cnt_q, l_q);
        sh       = mode_q ? (l_q - stage_q - SW'(1)) : stage_q;
        ksh      = SW'(MAX_LOG2N - 1) - sh;
        b        = cnt_q >> 1;
        span_m1  = (AW'(1) << sh) - AW'(1);
        x0       = ((b >> sh) << (sh + SW'(1))) | (b & span_m1);
        x1       = x0 + span_m1 + AW'(1);
        k_c      = (AW-1)'(b & span_m1) << ksh;
        load_wr  = (state_q == S_LOAD) && bus.in_valid;
        rd_addr_c = '0;
        if (state_q == S_COMPUTE)     rd_addr_c = cnt_q[0] ? x1 : x0;
        else if (state_q == S_UNLOAD) rd_addr_c = mode_q ? rev_cnt : cnt_q;
        l_in = ((bus.log2n == '0) || (bus.log2n > SW'(MAX_LOG2N))) ? SW'(MAX_LOG2N) : bus.log2n;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        l_d     = l_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_LOAD;
                mode_d  = bus.mode_dif;
                l_d     = l_in;
                stage_d = '0;
                cnt_d   = '0;
            end
            S_LOAD: if (bus.in_valid) begin
                cnt_d = cnt_q + AW'(1);
                if (last_cnt) begin
                    state_d = S_COMPUTE;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + AW'(1);
                if (last_cnt) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    drain_d = DW'(PIPE_LAT - 1);
                end
            end
            S_DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q == '0) begin
                    cnt_d = '0;
                    if (stage_q == l_q - SW'(1)) begin
                        state_d = S_UNLOAD;
                    end else begin
                        state_d = S_COMPUTE;
                        stage_d = stage_q + SW'(1);
                    end
                end
            end
            S_UNLOAD: begin
                cnt_d = cnt_q + AW'(1);
                if (last_cnt) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Only butterfly reads are written back; unload reads must not overwrite the result.
    always_comb begin
        dly_en_d      = '0;
        dly_en_d[0]   = (state_q == S_COMPUTE);
        dly_addr_d[0] = (state_q == S_COMPUTE) ? rd_addr_c : '0;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dly_en_d[i]   = dly_en_q[i-1];
            dly_addr_d[i] = dly_addr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            l_q      <= '0;
            stage_q  <= '0;
            cnt_q    <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            dly_en_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) dly_addr_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            l_q      <= l_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            dly_en_q <= dly_en_d;
            for (int i = 0; i < PIPE_LAT; i++) dly_addr_q[i] <= dly_addr_d[i];
        end
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.rd_en     = (state_q == S_COMPUTE) || (state_q == S_UNLOAD);
    assign bus.rd_addr   = rd_addr_c;
    assign bus.wr_en     = load_wr || dly_en_q[PIPE_LAT-1];
    assign bus.wr_addr   = load_wr ? (mode_q ? cnt_q : rev_cnt) : dly_addr_q[PIPE_LAT-1];
    assign bus.wr_sel_in = load_wr;
    assign bus.k         = (state_q == S_COMPUTE) ? k_c : '0;
    assign bus.stage     = stage_q;
    assign bus.out_last  = (state_q == S_UNLOAD) && last_cnt;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_fft_addr_gen_cfg.sv
// Directed bench for fft_addr_gen_cfg: hand-computed address/twiddle tables for small sizes plus spot checks.
module tb_fft_addr_gen_cfg;
    localparam int MAXL = 13;
    localparam int PL   = 3;
    localparam int SW   = 4;
    localparam int AW   = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_addr_gen_cfg_if #(.MAX_LOG2N(MAXL)) bus ();
    fft_addr_gen_cfg #(.MAX_LOG2N(MAXL), .PIPE_LAT(PL)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic [AW-2:0] k;
        logic [SW-1:0] stage;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic          wr_sel;
        logic          out_last;
        logic          done;
        logic          busy;
        logic          in_ready;
    } rec_t;

    rec_t lg [0:16400];
    int n_tests = 0;
    int n_fail  = 0;
    int done_cyc;

    // Cycle 0 is the edge that samples start; lg[c] holds outputs during cycle c.
    task automatic run(input bit dif, input logic [SW-1:0] l2n, input bit gap, input int ign_cyc,
                       input int max_cyc, input bit expect_done);
        bus.start = 1'b1; bus.mode_dif = dif; bus.log2n = l2n;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            bus.in_valid = gap ? (c % 2 == 0) : 1'b1;
            if (c == ign_cyc) begin
                bus.start = 1'b1; bus.mode_dif = ~dif; bus.log2n = 4'd2;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lg[c] = '{bus.rd_en, bus.rd_addr, bus.k, bus.stage, bus.wr_en, bus.wr_addr,
                      bus.wr_sel_in, bus.out_last, bus.done, bus.busy, bus.in_ready};
            if (bus.done) begin done_cyc = c; break; end
            if (c == max_cyc) break;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.start = 1'b0; bus.mode_dif = dif;
        if (expect_done) begin
            n_tests++;
            if (done_cyc < 0) begin n_fail++; $display("FAIL run_timeout: done not seen within %0d cycles", max_cyc); end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 0; bus.in_valid = 0; bus.mode_dif = 0; bus.log2n = '0;
        repeat (2) @(posedge clk); #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.in_ready, bus.out_last} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy/done/in_ready/out_last=%b exp 0000", {bus.busy, bus.done, bus.in_ready, bus.out_last});
        end
        n_tests++;
        if ({bus.rd_en, bus.wr_en, bus.wr_sel_in} !== 3'b0) begin
            n_fail++; $display("FAIL reset_strobes: rd/wr/sel=%b exp 000", {bus.rd_en, bus.wr_en, bus.wr_sel_in});
        end
        n_tests++;
        if (bus.rd_addr !== 0 || bus.wr_addr !== 0 || bus.k !== 0 || bus.stage !== 0) begin
            n_fail++; $display("FAIL reset_fields: rd_addr=%0d wr_addr=%0d k=%0d stage=%0d exp all 0", bus.rd_addr, bus.wr_addr, bus.k, bus.stage);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dit_l3();
        int wa [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int s1 [8] = '{0, 2, 1, 3, 4, 6, 5, 7};
        int s2 [8] = '{0, 4, 1, 5, 2, 6, 3, 7};
        int k1 [8] = '{0, 0, 2048, 2048, 0, 0, 2048, 2048};
        int k2 [8] = '{0, 0, 1024, 1024, 2048, 2048, 3072, 3072};
        run(1'b0, 4'd3, 1'b0, 0, 60, 1'b1);
        n_tests++;
        if (done_cyc != 50) begin n_fail++; $display("FAIL dit3_done_cycle: got %0d exp 50", done_cyc); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (!(lg[1+i].wr_en && lg[1+i].wr_sel && lg[1+i].in_ready) || lg[1+i].wr_addr !== AW'(wa[i])) begin
                n_fail++; $display("FAIL dit3_load[%0d]: wr_addr=%0d en=%b sel=%b exp %0d", i, lg[1+i].wr_addr, lg[1+i].wr_en, lg[1+i].wr_sel, wa[i]);
            end
            n_tests++;
            if (!lg[9+i].rd_en || lg[9+i].rd_addr !== AW'(i) || lg[9+i].k !== 0 || lg[9+i].stage !== 0) begin
                n_fail++; $display("FAIL dit3_s0[%0d]: rd_addr=%0d k=%0d stage=%0d exp %0d/0/0", i, lg[9+i].rd_addr, lg[9+i].k, lg[9+i].stage, i);
            end
            n_tests++;
            if (lg[20+i].rd_addr !== AW'(s1[i]) || lg[20+i].k !== 12'(k1[i]) || lg[20+i].stage !== 1) begin
                n_fail++; $display("FAIL dit3_s1[%0d]: rd_addr=%0d k=%0d stage=%0d exp %0d/%0d/1", i, lg[20+i].rd_addr, lg[20+i].k, lg[20+i].stage, s1[i], k1[i]);
            end
            n_tests++;
            if (lg[31+i].rd_addr !== AW'(s2[i]) || lg[31+i].k !== 12'(k2[i]) || lg[31+i].stage !== 2) begin
                n_fail++; $display("FAIL dit3_s2[%0d]: rd_addr=%0d k=%0d stage=%0d exp %0d/%0d/2", i, lg[31+i].rd_addr, lg[31+i].k, lg[31+i].stage, s2[i], k2[i]);
            end
            n_tests++;
            if (!lg[42+i].rd_en || lg[42+i].rd_addr !== AW'(i) || lg[42+i].out_last !== (i == 7)) begin
                n_fail++; $display("FAIL dit3_unload[%0d]: rd_addr=%0d out_last=%b exp %0d/%b", i, lg[42+i].rd_addr, lg[42+i].out_last, i, i == 7);
            end
        end
    endtask

    task automatic test_writeback();
        int s1 [8] = '{0, 2, 1, 3, 4, 6, 5, 7};
        int s2 [8] = '{0, 4, 1, 5, 2, 6, 3, 7};
        bit e_rd [0:60];
        bit e_wr [0:60];
        int e_wa [0:60];
        for (int c = 0; c <= 60; c++) begin e_rd[c] = 0; e_wr[c] = 0; e_wa[c] = 0; end
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 8; i++) begin
                e_rd[9 + 11*s + i]     = 1;
                e_wr[12 + 11*s + i]    = 1;
                e_wa[12 + 11*s + i]    = (s == 0) ? i : (s == 1) ? s1[i] : s2[i];
            end
        for (int i = 0; i < 8; i++) e_rd[42+i] = 1;
        @(negedge clk);
        run(1'b0, 4'd3, 1'b0, 0, 60, 1'b1);
        for (int c = 9; c <= 50; c++) begin
            n_tests++;
            if (lg[c].rd_en !== e_rd[c] || lg[c].wr_en !== e_wr[c] || (e_wr[c] && (lg[c].wr_addr !== AW'(e_wa[c]) || lg[c].wr_sel !== 1'b0))) begin
                n_fail++; $display("FAIL writeback[c%0d]: rd_en=%b wr_en=%b wr_addr=%0d sel=%b exp %b/%b/%0d/0", c, lg[c].rd_en, lg[c].wr_en, lg[c].wr_addr, lg[c].wr_sel, e_rd[c], e_wr[c], e_wa[c]);
            end
        end
    endtask

    task automatic test_dif_l3_start_ignored();
        int d0 [8] = '{0, 4, 1, 5, 2, 6, 3, 7};
        int d1 [8] = '{0, 2, 1, 3, 4, 6, 5, 7};
        int kk0 [8] = '{0, 0, 1024, 1024, 2048, 2048, 3072, 3072};
        int kk1 [8] = '{0, 0, 2048, 2048, 0, 0, 2048, 2048};
        int un [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        @(negedge clk);
        run(1'b1, 4'd3, 1'b0, 12, 60, 1'b1);
        n_tests++;
        if (done_cyc != 50) begin n_fail++; $display("FAIL dif3_done_cycle: got %0d exp 50", done_cyc); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (lg[1+i].wr_addr !== AW'(i) || !lg[1+i].wr_sel) begin
                n_fail++; $display("FAIL dif3_load[%0d]: wr_addr=%0d sel=%b exp %0d/1", i, lg[1+i].wr_addr, lg[1+i].wr_sel, i);
            end
            n_tests++;
            if (lg[9+i].rd_addr !== AW'(d0[i]) || lg[9+i].k !== 12'(kk0[i])) begin
                n_fail++; $display("FAIL dif3_s0[%0d]: rd_addr=%0d k=%0d exp %0d/%0d", i, lg[9+i].rd_addr, lg[9+i].k, d0[i], kk0[i]);
            end
            n_tests++;
            if (lg[20+i].rd_addr !== AW'(d1[i]) || lg[20+i].k !== 12'(kk1[i])) begin
                n_fail++; $display("FAIL dif3_s1[%0d]: rd_addr=%0d k=%0d exp %0d/%0d", i, lg[20+i].rd_addr, lg[20+i].k, d1[i], kk1[i]);
            end
            n_tests++;
            if (lg[31+i].rd_addr !== AW'(i) || lg[31+i].k !== 0) begin
                n_fail++; $display("FAIL dif3_s2[%0d]: rd_addr=%0d k=%0d exp %0d/0", i, lg[31+i].rd_addr, lg[31+i].k, i);
            end
            n_tests++;
            if (lg[42+i].rd_addr !== AW'(un[i]) || lg[42+i].out_last !== (i == 7)) begin
                n_fail++; $display("FAIL dif3_unload[%0d]: rd_addr=%0d out_last=%b exp %0d/%b", i, lg[42+i].rd_addr, lg[42+i].out_last, un[i], i == 7);
            end
        end
    endtask

    task automatic test_load_gaps();
        int wa [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        @(negedge clk);
        run(1'b0, 4'd3, 1'b1, 0, 80, 1'b1);
        n_tests++;
        if (done_cyc != 58) begin n_fail++; $display("FAIL gaps_done_cycle: got %0d exp 58", done_cyc); end
        for (int c = 1; c <= 16; c++) begin
            n_tests++;
            if (!lg[c].in_ready || lg[c].wr_en !== (c % 2 == 0) ||
                ((c % 2 == 0) && (lg[c].wr_addr !== AW'(wa[c/2-1]) || !lg[c].wr_sel))) begin
                n_fail++; $display("FAIL gaps_load[c%0d]: in_ready=%b wr_en=%b wr_addr=%0d", c, lg[c].in_ready, lg[c].wr_en, lg[c].wr_addr);
            end
        end
        n_tests++;
        if (lg[17].in_ready || !lg[17].rd_en || lg[17].rd_addr !== 0) begin
            n_fail++; $display("FAIL gaps_first_read: in_ready=%b rd_en=%b rd_addr=%0d exp 0/1/0", lg[17].in_ready, lg[17].rd_en, lg[17].rd_addr);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clk);
        run(1'b0, 4'd3, 1'b0, 0, 25, 1'b0);
        n_tests++;
        if (lg[25].stage !== 1 || lg[25].rd_addr !== 6) begin
            n_fail++; $display("FAIL rstmid_pos: stage=%0d rd_addr=%0d exp 1/6", lg[25].stage, lg[25].rd_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.busy || bus.in_ready || bus.rd_en || bus.wr_en || bus.done) begin
            n_fail++; $display("FAIL rstmid_idle: busy=%b rd_en=%b wr_en=%b done=%b exp 0", bus.busy, bus.rd_en, bus.wr_en, bus.done);
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.wr_en || bus.done || bus.busy) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d cycles with wr_en/done/busy exp 0", bad); end
        run(1'b0, 4'd3, 1'b0, 0, 60, 1'b1);
        n_tests++;
        if (done_cyc != 50 || lg[21].rd_addr !== 2) begin
            n_fail++; $display("FAIL rstmid_rerun: done=%0d rd_addr(c21)=%0d exp 50/2", done_cyc, lg[21].rd_addr);
        end
    endtask

    task automatic test_l13_and_clamp();
        @(negedge clk);
        run(1'b0, 4'd13, 1'b0, 0, 16392, 1'b0);
        n_tests++;
        if (lg[2].wr_addr !== 4096 || lg[3].wr_addr !== 2048 || lg[8192].wr_addr !== 8191) begin
            n_fail++; $display("FAIL l13_load: %0d %0d %0d exp 4096 2048 8191", lg[2].wr_addr, lg[3].wr_addr, lg[8192].wr_addr);
        end
        n_tests++;
        if (lg[8193].rd_addr !== 0 || lg[8194].rd_addr !== 1 || lg[8194].k !== 0 || lg[16384].rd_addr !== 8191) begin
            n_fail++; $display("FAIL l13_s0: %0d %0d k=%0d last=%0d exp 0 1 0 8191", lg[8193].rd_addr, lg[8194].rd_addr, lg[8194].k, lg[16384].rd_addr);
        end
        n_tests++;
        if (lg[16385].rd_en || !lg[16387].wr_en || lg[16387].wr_addr !== 8191 || lg[16388].stage !== 1 || lg[16388].rd_addr !== 0) begin
            n_fail++; $display("FAIL l13_drain: rd_en=%b wr_en=%b wr_addr=%0d stage=%0d", lg[16385].rd_en, lg[16387].wr_en, lg[16387].wr_addr, lg[16388].stage);
        end
        n_tests++;
        if (lg[16390].rd_addr !== 1 || lg[16390].k !== 2048 || lg[16391].rd_addr !== 3 || lg[16391].k !== 2048) begin
            n_fail++; $display("FAIL l13_s1: %0d k=%0d %0d k=%0d exp 1/2048 3/2048", lg[16390].rd_addr, lg[16390].k, lg[16391].rd_addr, lg[16391].k);
        end
        pulse_reset();
        run(1'b0, 4'd15, 1'b0, 0, 4, 1'b0);
        n_tests++;
        if (lg[2].wr_addr !== 4096) begin n_fail++; $display("FAIL clamp15: wr_addr=%0d exp 4096", lg[2].wr_addr); end
        pulse_reset();
        run(1'b0, 4'd0, 1'b0, 0, 4, 1'b0);
        n_tests++;
        if (lg[2].wr_addr !== 4096) begin n_fail++; $display("FAIL clamp0: wr_addr=%0d exp 4096", lg[2].wr_addr); end
        pulse_reset();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        run(1'b1, 4'd5, 1'b0, 0, 300, 1'b1);
        n_tests++;
        if (done_cyc != 240 || lg[2].wr_addr !== 1 || lg[34].rd_addr !== 16 || lg[35].rd_addr !== 1 ||
            lg[36].rd_addr !== 17 || lg[36].k !== 256) begin
            n_fail++; $display("FAIL b2b_l5: done=%0d rd34=%0d rd36=%0d k36=%0d exp 240/16/17/256", done_cyc, lg[34].rd_addr, lg[36].rd_addr, lg[36].k);
        end
        run(1'b0, 4'd4, 1'b0, 0, 150, 1'b1);
        n_tests++;
        if (done_cyc != 109) begin n_fail++; $display("FAIL b2b_l4_done: got %0d exp 109", done_cyc); end
        for (int c = 1; c <= 109; c++) begin
            if (lg[c].rd_addr > 15 || lg[c].wr_addr > 15) bad++;
            if (c >= 17 && c <= 32 && lg[c].k !== 0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_l4_range: %0d out-of-range addr or nonzero s0 k exp 0", bad); end
        n_tests++;
        if (lg[2].wr_addr !== 8 || lg[38].rd_addr !== 1 || lg[39].rd_addr !== 3 || lg[39].k !== 2048) begin
            n_fail++; $display("FAIL b2b_l4_s1: wr2=%0d rd38=%0d rd39=%0d k=%0d exp 8/1/3/2048", lg[2].wr_addr, lg[38].rd_addr, lg[39].rd_addr, lg[39].k);
        end
        n_tests++;
        if (lg[76].rd_addr !== 1 || lg[77].rd_addr !== 9 || lg[77].k !== 512 || lg[77].stage !== 3) begin
            n_fail++; $display("FAIL b2b_l4_s3: rd76=%0d rd77=%0d k=%0d stage=%0d exp 1/9/512/3", lg[76].rd_addr, lg[77].rd_addr, lg[77].k, lg[77].stage);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dit_l3();
        test_writeback();
        test_dif_l3_start_ignored();
        test_load_gaps();
        test_reset_mid();
        test_l13_and_clamp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
